// File: rtl/cpu_controller_if.sv
// Instruction/handshake bundle between the host side and the controller,
// plus every datapath control the controller produces.
interface cpu_controller_if #(parameter int DATA_W = 16);
    logic [15:0]       in;
    logic              load;
    logic              s;
    logic              w;
    logic [2:0]        readnum;
    logic [2:0]        writenum;
    logic              write;
    logic              vsel;
    logic              loada;
    logic              loadb;
    logic              asel;
    logic              bsel;
    logic [1:0]        shift;
    logic [1:0]        ALUop;
    logic              loadc;
    logic              loads;
    logic [DATA_W-1:0] datapath_in;
    logic              illegal;

    modport master (
        output in, load, s,
        input  w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, datapath_in, illegal
    );

    modport slave (
        input  in, load, s,
        output w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, datapath_in, illegal
    );
endinterface

// File: rtl/cpu_controller.sv
// Instruction register, decoder and sequencing FSM for the 16-bit datapath.
// One instruction per s pulse in WAIT; all controls are Moore outputs of state + IR.
module cpu_controller #(
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    cpu_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_arith, is_cmp, is_mvn;

    assign opc = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
    assign is_arith   = (opc == 3'b101);
    assign is_cmp     = is_arith && (op == 2'b01);
    assign is_mvn     = is_arith && (op == 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (bus.load) ir_d = bus.in;
                if (bus.s)    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)                    state_d = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn)     state_d = S_GET_B;
                else if (is_arith)                 state_d = S_GET_A;
                else                               state_d = S_WAIT;
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    assign bus.w           = (state_q == S_WAIT);
    assign bus.bsel        = 1'b0;
    assign bus.datapath_in = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

    // Controls are masked while reset is high so an interrupted instruction
    // never leaks a write or load pulse in the reset cycle.
    always_comb begin
        bus.readnum  = '0;
        bus.writenum = '0;
        bus.write    = 1'b0;
        bus.vsel     = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.asel     = 1'b0;
        bus.shift    = '0;
        bus.ALUop    = '0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_DECODE: bus.illegal = !(is_mov_imm || is_mov_reg || is_arith);
                S_WRITE_IMM: begin
                    bus.writenum = rn;
                    bus.vsel     = 1'b1;
                    bus.write    = 1'b1;
                end
                S_GET_A: begin
                    bus.readnum = rn;
                    bus.loada   = 1'b1;
                end
                S_GET_B: begin
                    bus.readnum = rm;
                    bus.loadb   = 1'b1;
                end
                S_ALU: begin
                    bus.shift = sh;
                    bus.asel  = is_mov_reg || is_mvn;
                    bus.ALUop = is_mov_reg ? 2'b00 : op;
                    bus.loads = is_cmp;
                    bus.loadc = !is_cmp;
                end
                S_WRITE_REG: begin
                    bus.writenum = rd;
                    bus.write    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench: stimulus pushes hand-computed per-cycle expected
// controls into a queue, a negedge monitor pops and compares.
module tb_cpu_controller;
    logic clk = 1'b0;
    logic reset;

    cpu_controller_if #(.DATA_W(16)) bif ();

    cpu_controller #(.DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [35:0] v;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Field order: w rn wn write vsel loada loadb asel bsel shift ALUop loadc loads illegal dp
    function automatic logic [35:0] pk(input logic w, input logic [2:0] rn, input logic [2:0] wn,
                                       input logic wr, input logic vs, input logic la,
                                       input logic lb, input logic as, input logic [1:0] sh,
                                       input logic [1:0] alu, input logic lc, input logic ls,
                                       input logic il, input logic [15:0] dp);
        return {w, rn, wn, wr, vs, la, lb, as, 1'b0, sh, alu, lc, ls, il, dp};
    endfunction

    function automatic logic [35:0] idle(input logic [15:0] dp);
        return pk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, dp);
    endfunction

    function automatic logic [35:0] busy(input logic [15:0] dp);
        return pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, dp);
    endfunction

    always @(negedge clk) begin
        logic [35:0] act;
        exp_t        e;
        act = {bif.w, bif.readnum, bif.writenum, bif.write, bif.vsel, bif.loada, bif.loadb,
               bif.asel, bif.bsel, bif.shift, bif.ALUop, bif.loadc, bif.loads, bif.illegal,
               bif.datapath_in};
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.tag, act, e.v);
            end
            n_chk++;
            if (bif.write === 1'b1 && bif.loadc === 1'b1) begin
                n_fail++;
                $display("FAIL %s write_loadc_overlap: got write=1 loadc=1 expected not both", e.tag);
            end
        end
    end

    task automatic cyc(input string tag, input logic [15:0] i, input logic ld, input logic st,
                       input logic rs, input logic [35:0] ev);
        @(posedge clk);
        #1;
        bif.in   = i;
        bif.load = ld;
        bif.s    = st;
        reset    = rs;
        q.push_back('{tag, ev});
    endtask

    initial begin
        reset    = 1'b1;
        bif.in   = '0;
        bif.load = 1'b0;
        bif.s    = 1'b0;
        @(posedge clk);
        cyc("reset", 16'h0, 0, 0, 1, idle(16'h0000));

        // MOV R0,#-3
        cyc("movi_wait", 16'hD0FD, 1, 1, 0, idle(16'h0000));
        cyc("movi_dec",  16'h0, 0, 0, 0, busy(16'hFFFD));
        cyc("movi_wr",   16'h0, 0, 0, 0, pk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'hFFFD));
        cyc("movi_done", 16'h0, 0, 0, 0, idle(16'hFFFD));

        // ADD R2,R1,R0,LSL with load/s hammered while busy
        cyc("add_wait",  16'hA148, 1, 1, 0, idle(16'hFFFD));
        cyc("add_dec",   16'hFFFF, 1, 1, 0, busy(16'h0048));
        cyc("add_geta",  16'hFFFF, 1, 1, 0, pk(0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'h0048));
        cyc("add_getb",  16'hFFFF, 1, 1, 0, pk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 16'h0048));
        cyc("add_alu",   16'hFFFF, 1, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0, 16'h0048));
        cyc("add_wr",    16'hFFFF, 1, 1, 0, pk(0, 0, 2, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'h0048));
        cyc("add_done",  16'h0, 0, 0, 0, idle(16'h0048));

        // CMP R3,R4
        cyc("cmp_wait",  16'hAB04, 1, 1, 0, idle(16'h0048));
        cyc("cmp_dec",   16'h0, 0, 0, 0, busy(16'h0004));
        cyc("cmp_geta",  16'h0, 0, 0, 0, pk(0, 3, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'h0004));
        cyc("cmp_getb",  16'h0, 0, 0, 0, pk(0, 4, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 16'h0004));
        cyc("cmp_alu",   16'h0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 16'h0004));
        cyc("cmp_done",  16'h0, 0, 0, 0, idle(16'h0004));

        // MOV R5,R3,LSR
        cyc("movr_wait", 16'hC0B3, 1, 1, 0, idle(16'h0004));
        cyc("movr_dec",  16'h0, 0, 0, 0, busy(16'hFFB3));
        cyc("movr_getb", 16'h0, 0, 0, 0, pk(0, 3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 16'hFFB3));
        cyc("movr_alu",  16'h0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 1, 0, 0, 16'hFFB3));
        cyc("movr_wr",   16'h0, 0, 0, 0, pk(0, 0, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'hFFB3));
        cyc("movr_done", 16'h0, 0, 0, 0, idle(16'hFFB3));

        // MVN R1,R6,ASR
        cyc("mvn_wait",  16'hB83E, 1, 1, 0, idle(16'hFFB3));
        cyc("mvn_dec",   16'h0, 0, 0, 0, busy(16'h003E));
        cyc("mvn_getb",  16'h0, 0, 0, 0, pk(0, 6, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 16'h003E));
        cyc("mvn_alu",   16'h0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 2'b11, 1, 0, 0, 16'h003E));
        cyc("mvn_wr",    16'h0, 0, 0, 0, pk(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'h003E));
        cyc("mvn_done",  16'h0, 0, 0, 0, idle(16'h003E));

        // AND R7,R2,R1
        cyc("and_wait",  16'hB2E1, 1, 1, 0, idle(16'h003E));
        cyc("and_dec",   16'h0, 0, 0, 0, busy(16'hFFE1));
        cyc("and_geta",  16'h0, 0, 0, 0, pk(0, 2, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'hFFE1));
        cyc("and_getb",  16'h0, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 16'hFFE1));
        cyc("and_alu",   16'h0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0, 16'hFFE1));
        cyc("and_wr",    16'h0, 0, 0, 0, pk(0, 0, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'hFFE1));
        cyc("and_done",  16'h0, 0, 0, 0, idle(16'hFFE1));

        // ADD interrupted by reset in GET_B
        cyc("rst_wait",  16'hA148, 1, 1, 0, idle(16'hFFE1));
        cyc("rst_dec",   16'h0, 0, 0, 0, busy(16'h0048));
        cyc("rst_geta",  16'h0, 0, 0, 0, pk(0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'h0048));
        cyc("rst_getb",  16'h0, 0, 0, 1, busy(16'h0048));
        cyc("rst_after", 16'h0, 0, 0, 0, idle(16'h0000));
        cyc("rst_idle",  16'h0, 0, 0, 0, idle(16'h0000));

        // Illegal opcode 000, s held through DECODE
        cyc("ill_wait",  16'h0000, 1, 1, 0, idle(16'h0000));
        cyc("ill_dec",   16'h0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 16'h0000));
        cyc("ill_done",  16'h0, 0, 0, 0, idle(16'h0000));
        cyc("ill_idle",  16'h0, 0, 0, 0, idle(16'h0000));

        // Illegal 110/01
        cyc("ill2_wait", 16'hC800, 1, 1, 0, idle(16'h0000));
        cyc("ill2_dec",  16'h0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 16'h0000));
        cyc("ill2_done", 16'h0, 0, 0, 0, idle(16'h0000));

        // Reset beats a simultaneous load/s in WAIT
        cyc("rstld",     16'h12F4, 1, 1, 1, idle(16'h0000));
        cyc("rstld_aft", 16'h0, 0, 0, 0, idle(16'h0000));
        cyc("rstld_idl", 16'h0, 0, 0, 0, idle(16'h0000));

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
